// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared types and constants for the candidate search block
package md5_pkg;

  localparam int DIGEST_W = 128;
  localparam int MSG_W    = 128;
  localparam int MAX_LEN  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_FOUND,
    ST_DONE
  } state_t;

  // Candidate length must fit in the 16-byte message
  function automatic bit len_ok(input int len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/charset_ram.sv
// rtl/charset_ram.sv - charset memory, one write port and one registered read port
module charset_ram #(
  parameter int CHAR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [CHAR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [CHAR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [2**CHAR_BITS];

  // Contents survive reset; read data appears one cycle after the address
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/md5_search.sv
// rtl/md5_search.sv - enumerates charset candidates and feeds them to an external hash core
module md5_search
  import md5_pkg::*;
#(
  parameter int CHAR_BITS = 6,
  parameter int LEN       = 8,
  parameter int CNT_W     = LEN * CHAR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIGEST_W-1:0]  target,
  input  logic [CNT_W-1:0]     start_idx,
  input  logic                 cs_we,
  input  logic [CHAR_BITS-1:0] cs_addr,
  input  logic [7:0]           cs_di,
  output logic [MSG_W-1:0]     msg_in,
  output logic [7:0]           msg_in_width,
  output logic                 msg_in_valid,
  input  logic                 core_ready,
  input  logic [DIGEST_W-1:0]  msg_output,
  input  logic                 msg_out_valid,
  output logic                 busy,
  output logic                 found,
  output logic                 done,
  output logic [MSG_W-1:0]     match_msg,
  output logic [CNT_W-1:0]     match_idx
);

  if (!len_ok(LEN)) begin : g_len_check
    $error("md5_search: LEN must be in 1..16");
  end

  state_t               state, state_nx;
  logic [DIGEST_W-1:0]  target_q;
  logic [CNT_W-1:0]     counter, f_idx, inflight_idx;
  logic [MSG_W-1:0]     stage, inflight_msg;
  logic [4:0]           f_cnt, wr_byte;
  logic                 f_run, f_done;
  logic [CHAR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic                 go_start, accept, result, hit;

  // Fetch cycle k addresses the charset with digit k of the candidate index
  assign rd_addr      = CHAR_BITS'(f_idx >> (CHAR_BITS * int'(f_cnt)));
  assign wr_byte      = f_cnt - 5'd1;
  assign msg_in       = msg_in_valid ? stage : '0;
  assign msg_in_width = 8'(8 * LEN);

  charset_ram #(.CHAR_BITS(CHAR_BITS)) u_charset (
    .clk     (clk),
    .we      (cs_we && (state == ST_IDLE)),
    .wr_addr (cs_addr),
    .wr_data (cs_di),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state, event strobes and status outputs; abort overrides everything
  always_comb begin
    state_nx     = state;
    go_start     = 1'b0;
    accept       = 1'b0;
    result       = 1'b0;
    hit          = 1'b0;
    msg_in_valid = (state == ST_ISSUE);
    busy         = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT);
    found        = (state == ST_FOUND);
    done         = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_FOUND, ST_DONE: begin
        if (start) begin
          go_start = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: if (f_done) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (core_ready) begin
          accept   = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (msg_out_valid) begin
          result = 1'b1;
          if (msg_output == target_q) begin
            hit      = 1'b1;
            state_nx = ST_FOUND;
          end else if (inflight_idx == '1) begin
            state_nx = ST_DONE;
          end else if (f_done) begin
            state_nx = ST_ISSUE;
          end else begin
            state_nx = ST_FETCH;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) begin
      state_nx = ST_IDLE;
      go_start = 1'b0;
      accept   = 1'b0;
      result   = 1'b0;
      hit      = 1'b0;
    end
  end

  // Search bookkeeping: counter, target, in-flight copy and match capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter      <= '0;
      target_q     <= '0;
      inflight_msg <= '0;
      inflight_idx <= '0;
      match_msg    <= '0;
      match_idx    <= '0;
    end else begin
      if (go_start) begin
        counter   <= start_idx;
        target_q  <= target;
        match_msg <= '0;
        match_idx <= '0;
      end
      if (accept) begin
        inflight_msg <= stage;
        inflight_idx <= counter;
      end
      if (result && !hit) counter <= counter + CNT_W'(1);
      if (hit) begin
        match_msg <= inflight_msg;
        match_idx <= inflight_idx;
      end
    end
  end

  // Fetch engine: LEN address cycles plus one drain cycle into the staging buffer;
  // relaunched on accept so the next candidate is ready while the core works
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_run  <= 1'b0;
      f_done <= 1'b0;
      f_cnt  <= '0;
      f_idx  <= '0;
      stage  <= '0;
    end else if (abort) begin
      f_run  <= 1'b0;
      f_done <= 1'b0;
    end else if (go_start || accept) begin
      f_run  <= 1'b1;
      f_done <= 1'b0;
      f_cnt  <= '0;
      f_idx  <= go_start ? start_idx : counter + CNT_W'(1);
    end else if (f_run) begin
      if (f_cnt != 5'd0) stage[MSG_W - 1 - 8 * int'(wr_byte) -: 8] <= rd_data;
      if (int'(f_cnt) == LEN) begin
        f_run  <= 1'b0;
        f_done <= 1'b1;
      end
      f_cnt <= f_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_md5_search.sv
// tb/tb_md5_search.sv - directed bench for md5_search with a stand-in hash core
module tb_md5_search;

  localparam int CB = 2;
  localparam int L  = 2;
  localparam int CW = 4;

  localparam logic [127:0] MSG_AA = {8'h61, 8'h61, 112'h0};
  localparam logic [127:0] MSG_BA = {8'h62, 8'h61, 112'h0};
  localparam logic [127:0] MSG_DD = {8'h64, 8'h64, 112'h0};
  localparam logic [127:0] NO_HIT = {128{1'b1}};

  logic          clk = 1'b0;
  logic          reset, start, abort, cs_we, core_ready, msg_out_valid;
  logic [127:0]  target, msg_output, msg_in, match_msg;
  logic [CW-1:0] start_idx, match_idx;
  logic [CB-1:0] cs_addr;
  logic [7:0]    cs_di, msg_in_width;
  logic          msg_in_valid, busy, found, done;

  int n_vec = 0;
  int n_miss = 0;

  int           core_lat = 3;
  int           req_cnt = 0;
  int           cd = 0;
  bit           pend = 0;
  logic [127:0] pend_msg = '0;
  logic [127:0] last_req = '0;

  always #5 clk = ~clk;

  md5_search #(.CHAR_BITS(CB), .LEN(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .target        (target),
    .start_idx     (start_idx),
    .cs_we         (cs_we),
    .cs_addr       (cs_addr),
    .cs_di         (cs_di),
    .msg_in        (msg_in),
    .msg_in_width  (msg_in_width),
    .msg_in_valid  (msg_in_valid),
    .core_ready    (core_ready),
    .msg_output    (msg_output),
    .msg_out_valid (msg_out_valid),
    .busy          (busy),
    .found         (found),
    .done          (done),
    .match_msg     (match_msg),
    .match_idx     (match_idx)
  );

  // Stand-in digest: any fixed injective mapping serves for matching
  function automatic logic [127:0] fake_md5(input logic [127:0] m);
    return {m[63:0], m[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hash core model: accepts on valid&&ready, answers core_lat cycles later
  always @(negedge clk) begin
    msg_out_valid = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cd--;
        if (cd == 0) begin
          msg_out_valid = 1'b1;
          msg_output    = fake_md5(pend_msg);
          pend          = 1'b0;
        end
      end
      if (msg_in_valid && core_ready) begin
        req_cnt++;
        last_req = msg_in;
        pend_msg = msg_in;
        pend     = 1'b1;
        cd       = core_lat;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] idx, input logic [127:0] tgt);
    start_idx = idx;
    target    = tgt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 2000; i++) begin
      if (found || done) break;
      tick();
    end
    expect_eq("end_reached", found | done, 1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 100; i++) begin
      if (req_cnt > 0) break;
      tick();
    end
    expect_eq("req_seen", req_cnt > 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cs_we = 1'b0; core_ready = 1'b1;
    target = '0; start_idx = '0; cs_addr = '0; cs_di = '0;
    msg_output = '0; msg_out_valid = 1'b0;
    tick(3);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_found", found, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_valid", msg_in_valid, 0);
    expect_eq("rst_msg_in", msg_in, 0);
    expect_eq("rst_width", msg_in_width, 16);
    expect_eq("rst_match_msg", match_msg, 0);
    expect_eq("rst_match_idx", match_idx, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      cs_we   = 1'b1;
      cs_addr = CB'(i);
      cs_di   = 8'h61 + 8'(i);
      tick();
    end
    cs_we = 1'b0;

    // Target present: "ba" is index 1
    req_cnt = 0;
    do_start(0, fake_md5(MSG_BA));
    wait_end();
    expect_eq("hit_found", found, 1);
    expect_eq("hit_done", done, 0);
    expect_eq("hit_busy", busy, 0);
    expect_eq("hit_idx", match_idx, 1);
    expect_eq("hit_msg", match_msg, MSG_BA);
    expect_eq("hit_reqs", req_cnt, 2);
    tick(5);
    expect_eq("hit_hold", found, 1);

    // Target absent: whole space of 16 candidates
    req_cnt = 0;
    do_start(0, NO_HIT);
    wait_end();
    expect_eq("miss_found", found, 0);
    expect_eq("miss_done", done, 1);
    expect_eq("miss_reqs", req_cnt, 16);
    expect_eq("miss_last", last_req, MSG_DD);
    expect_eq("miss_idx_clr", match_idx, 0);

    // Start at the last index: one request then done, no wrap to 0
    req_cnt = 0;
    do_start(15, NO_HIT);
    wait_end();
    expect_eq("wrap_done", done, 1);
    tick(10);
    expect_eq("wrap_reqs", req_cnt, 1);
    expect_eq("wrap_last", last_req, MSG_DD);

    // Core stalls for 20 cycles in ISSUE
    core_ready = 1'b0;
    req_cnt = 0;
    do_start(0, fake_md5(MSG_BA));
    for (int i = 0; i < 50; i++) begin
      if (msg_in_valid) break;
      tick();
    end
    expect_eq("stall_first", msg_in, MSG_AA);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_eq("stall_valid", msg_in_valid, 1);
      expect_eq("stall_msg", msg_in, MSG_AA);
    end
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    tick(12);
    expect_eq("stall_one_accept", req_cnt, 1);
    expect_eq("stall_next_valid", msg_in_valid, 1);
    expect_eq("stall_next_msg", msg_in, MSG_BA);
    core_ready = 1'b1;
    wait_end();
    expect_eq("stall_found", found, 1);
    expect_eq("stall_idx", match_idx, 1);
    expect_eq("stall_reqs", req_cnt, 2);

    // Abort in the same cycle as a matching result
    req_cnt = 0;
    do_start(1, fake_md5(MSG_BA));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (msg_out_valid) break;
    end
    expect_eq("abort_res_seen", msg_out_valid, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    expect_eq("abort_busy", busy, 0);
    expect_eq("abort_found", found, 0);
    tick(10);
    expect_eq("abort_found_late", found, 0);
    expect_eq("abort_idx", match_idx, 0);

    // Abort in WAIT, matching result arrives while idle
    req_cnt = 0;
    do_start(1, fake_md5(MSG_BA));
    wait_req();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(8);
    expect_eq("late_found", found, 0);
    expect_eq("late_busy", busy, 0);
    expect_eq("late_done", done, 0);

    // Reset in WAIT, then a clean search with the retained charset
    req_cnt = 0;
    do_start(0, fake_md5(MSG_BA));
    wait_req();
    reset = 1'b0;
    #1;
    expect_eq("rw_busy", busy, 0);
    expect_eq("rw_valid", msg_in_valid, 0);
    expect_eq("rw_msg_in", msg_in, 0);
    expect_eq("rw_found", found, 0);
    expect_eq("rw_done", done, 0);
    expect_eq("rw_match_idx", match_idx, 0);
    tick(2);
    reset = 1'b1;
    tick(6);
    req_cnt = 0;
    do_start(0, fake_md5(MSG_BA));
    wait_end();
    expect_eq("rw_again_found", found, 1);
    expect_eq("rw_again_idx", match_idx, 1);
    expect_eq("rw_again_msg", match_msg, MSG_BA);
    expect_eq("rw_again_reqs", req_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
